// File: rtl/access_ctrl_regfile.sv
// access_ctrl_regfile
//   Small register file with per-register ownership and an admin override.
//   Data registers are readable/writable only by their owner or ADMIN_ID.
//   The owner table is readable by anyone, writable only by ADMIN_ID while
//   unlocked; writing an owner entry with the data MSB set locks the table
//   until reset. Repeated consecutive denials put the block into a timed
//   lockout during which no requests are accepted.
//
// Ports
//   clk, rst_n              clock, async active-low reset
//   req_valid / req_ready   request handshake
//   req_write, req_cfg      1 = write / 1 = owner table
//   req_addr, req_id        register index, requesting user ID
//   req_wdata               write data
//   rsp_valid               one-cycle strobe, one cycle after each accept
//   rsp_err, rsp_rdata      response status/data, qualified by rsp_valid
//   cfg_locked              owner table locked (sticky)
//   lockout                 block currently refusing requests
//   viol_cnt                saturating count of denied requests
//
// FSM states
//   state      | meaning
//   ST_OPEN    | accepting requests (req_ready = 1)
//   ST_LOCKOUT | refusing requests while the down-timer runs out
module access_ctrl_regfile #(
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 4,
  parameter int ID_W        = 3,
  parameter int ADMIN_ID    = 4,
  parameter int MAX_VIOL    = 3,
  parameter int LOCKOUT_CYC = 16,
  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_cfg,
  input  logic [AW-1:0]     req_addr,
  input  logic [ID_W-1:0]   req_id,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              cfg_locked,
  output logic              lockout,
  output logic [7:0]        viol_cnt
);

  localparam int CW = $clog2(MAX_VIOL + 1);
  localparam int TW = $clog2(LOCKOUT_CYC + 1);

  localparam logic [AW:0]     NREGS_L = (AW + 1)'(NUM_REGS);
  localparam logic [ID_W-1:0] ADMIN_L = ID_W'(ADMIN_ID);
  localparam logic [CW-1:0]   MAXV_L  = CW'(MAX_VIOL);
  localparam logic [TW-1:0]   TLOAD_L = TW'(LOCKOUT_CYC);
  localparam logic [TW-1:0]   TONE_L  = TW'(1);

  typedef enum logic {
    ST_OPEN    = 1'b0,
    ST_LOCKOUT = 1'b1
  } state_t;

  state_t state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [CW-1:0] consec, consec_nxt;
  logic [CW-1:0] consec_inc;

  logic [DATA_W-1:0] data_q  [NUM_REGS];
  logic [ID_W-1:0]   owner_q [NUM_REGS];

  logic              accept;
  logic              addr_ok;
  logic [AW-1:0]     idx;
  logic              grant;
  logic [DATA_W-1:0] rdata_nxt;

  // ---------------------------------------------------------------------
  // Grant decision: purely from the current request and current state,
  // so a change of ID in the very next cycle is honoured immediately.
  // ---------------------------------------------------------------------
  always_comb begin
    addr_ok = ({1'b0, req_addr} < NREGS_L);
    idx     = addr_ok ? req_addr : '0;
    accept  = req_valid && req_ready;
    grant   = 1'b0;
    if (addr_ok) begin
      if (req_cfg) begin
        grant = req_write ? ((req_id == ADMIN_L) && !cfg_locked) : 1'b1;
      end else begin
        grant = (req_id == owner_q[idx]) || (req_id == ADMIN_L);
      end
    end
  end

  always_comb begin
    rdata_nxt = '0;
    if (grant) begin
      if (req_cfg) begin
        rdata_nxt = req_write ? '0 : DATA_W'(owner_q[idx]);
      end else begin
        rdata_nxt = req_write ? req_wdata : data_q[idx];
      end
    end
  end

  // ---------------------------------------------------------------------
  // FSM: state, lockout down-timer and consecutive-denial counter
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_OPEN;
      timer  <= '0;
      consec <= '0;
    end else begin
      state  <= state_nxt;
      timer  <= timer_nxt;
      consec <= consec_nxt;
    end
  end

  assign consec_inc = consec + 1'b1;

  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    consec_nxt = consec;
    req_ready  = 1'b0;
    lockout    = 1'b0;
    case (state)
      ST_OPEN: begin
        req_ready = 1'b1;
        if (accept) begin
          if (grant) begin
            consec_nxt = '0;
          end else if (consec_inc == MAXV_L) begin
            // The triggering response is still issued by the datapath.
            consec_nxt = '0;
            timer_nxt  = TLOAD_L;
            state_nxt  = ST_LOCKOUT;
          end else begin
            consec_nxt = consec_inc;
          end
        end
      end
      ST_LOCKOUT: begin
        lockout = 1'b1;
        // Terminal count at 1 gives exactly LOCKOUT_CYC refused cycles;
        // the <= also recovers from a stray zero.
        if (timer <= TONE_L) begin
          timer_nxt = '0;
          state_nxt = ST_OPEN;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      default: begin
        state_nxt = ST_OPEN;
        timer_nxt = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Register file, owner table, lock and response
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        data_q[i]  <= '0;
        owner_q[i] <= ADMIN_L;
      end
      cfg_locked <= 1'b0;
    end else if (accept && grant && req_write) begin
      if (req_cfg) begin
        owner_q[idx] <= req_wdata[ID_W-1:0];
        if (req_wdata[DATA_W-1]) begin
          cfg_locked <= 1'b1;
        end
      end else begin
        data_q[idx] <= req_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      viol_cnt  <= '0;
    end else begin
      rsp_valid <= accept;
      rsp_err   <= accept && !grant;
      rsp_rdata <= accept ? rdata_nxt : '0;
      if (accept && !grant && (viol_cnt != 8'hFF)) begin
        viol_cnt <= viol_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_access_ctrl_regfile.sv
// Self-checking bench for access_ctrl_regfile (default parameters).
// Directed scenarios followed by randomized traffic, all compared against
// an array-based reference model of the access rules.
module tb_access_ctrl_regfile;

  localparam int DATA_W   = 8;
  localparam int NREG     = 4;
  localparam int ID_W     = 3;
  localparam int ADMIN    = 4;
  localparam int MAXV     = 3;
  localparam int LOCK_CYC = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic              req_cfg = 1'b0;
  logic [1:0]        req_addr = '0;
  logic [ID_W-1:0]   req_id = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              rsp_valid;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic              cfg_locked;
  logic              lockout;
  logic [7:0]        viol_cnt;

  int checks = 0;
  int failures = 0;

  // reference model state
  int m_data [NREG];
  int m_owner[NREG];
  bit m_locked;
  int m_viol;
  int m_consec;
  int m_left;

  access_ctrl_regfile dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_cfg(req_cfg),
    .req_addr(req_addr), .req_id(req_id), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .cfg_locked(cfg_locked), .lockout(lockout), .viol_cnt(viol_cnt)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_data[i]  = 0;
      m_owner[i] = ADMIN;
    end
    m_locked = 0;
    m_viol   = 0;
    m_consec = 0;
    m_left   = 0;
  endtask

  // Called at posedge+1; drives one cycle, returns at next posedge+1.
  task automatic do_req(input bit v, input bit w, input bit c, input int a,
                        input int id, input int wd, input string tag);
    bit acc, g;
    int erd;
    req_valid = v; req_write = w; req_cfg = c;
    req_addr = 2'(a); req_id = ID_W'(id); req_wdata = DATA_W'(wd);
    chk({tag, "/ready"}, {31'b0, req_ready}, (m_left == 0) ? 1 : 0);
    acc = v && (m_left == 0);
    if (m_left > 0) m_left--;
    g = 0; erd = 0;
    if (acc) begin
      if (c) begin
        if (w) begin
          g = (id == ADMIN) && !m_locked;
          if (g) begin
            m_owner[a] = wd % (1 << ID_W);
            if (wd >= 128) m_locked = 1;
          end
        end else begin
          g = 1; erd = m_owner[a];
        end
      end else begin
        g = (id == m_owner[a]) || (id == ADMIN);
        if (g) begin
          if (w) begin erd = wd; m_data[a] = wd; end
          else erd = m_data[a];
        end
      end
      if (g) m_consec = 0;
      else begin
        if (m_viol < 255) m_viol++;
        m_consec++;
        if (m_consec == MAXV) begin
          m_consec = 0;
          m_left = LOCK_CYC;
        end
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({tag, "/rsp_valid"}, {31'b0, rsp_valid}, acc ? 1 : 0);
    if (acc) begin
      chk({tag, "/rsp_err"}, {31'b0, rsp_err}, g ? 0 : 1);
      chk({tag, "/rsp_rdata"}, {24'b0, rsp_rdata}, erd);
    end
    chk({tag, "/cfg_locked"}, {31'b0, cfg_locked}, m_locked ? 1 : 0);
    chk({tag, "/lockout"}, {31'b0, lockout}, (m_left > 0) ? 1 : 0);
    chk({tag, "/viol_cnt"}, {24'b0, viol_cnt}, m_viol);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) do_req(0, 0, 0, 0, 0, 0, tag);
  endtask

  // Called at posedge+1; pulses reset between edges, checks asynchronously.
  task automatic pulse_reset(input string tag);
    #2 rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    chk({tag, "/rst_ready"}, {31'b0, req_ready}, 1);
    chk({tag, "/rst_lockout"}, {31'b0, lockout}, 0);
    chk({tag, "/rst_rsp_valid"}, {31'b0, rsp_valid}, 0);
    chk({tag, "/rst_rsp_err"}, {31'b0, rsp_err}, 0);
    chk({tag, "/rst_rdata"}, {24'b0, rsp_rdata}, 0);
    chk({tag, "/rst_locked"}, {31'b0, cfg_locked}, 0);
    chk({tag, "/rst_viol"}, {24'b0, viol_cnt}, 0);
    #2 rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    chk({tag, "/post_rst_valid"}, {31'b0, rsp_valid}, 0);
    chk({tag, "/post_rst_ready"}, {31'b0, req_ready}, 1);
  endtask

  initial begin
    model_reset();
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    pulse_reset("init");

    // reset contents visible through reads
    for (int a = 0; a < NREG; a++) begin
      do_req(1, 0, 0, a, ADMIN, 0, "rst_data_rd");
      do_req(1, 0, 1, a, 1, 0, "rst_owner_rd");
    end

    // basic write / denied read
    do_req(1, 1, 0, 1, 4, 8'hA5, "wr_a5");
    do_req(1, 0, 0, 1, 2, 0, "deny_rd");

    // owner change immediately honoured in the next cycle
    do_req(1, 1, 1, 1, 4, 8'h02, "own1_2");
    do_req(1, 1, 0, 1, 2, 8'h3C, "id2_wr");
    do_req(1, 0, 0, 1, 4, 0, "rd_3c");
    do_req(1, 0, 0, 1, 3, 0, "id3_deny");

    // back-to-back ID switching on data[0]
    do_req(1, 1, 0, 0, 4, 8'h11, "b2b_4a");
    do_req(1, 1, 0, 0, 1, 8'h22, "b2b_1a");
    do_req(1, 1, 0, 0, 4, 8'h33, "b2b_4b");
    do_req(1, 1, 0, 0, 1, 8'h44, "b2b_1b");
    do_req(1, 0, 0, 0, 4, 0, "b2b_rd");

    // permitted access breaks the denial run
    do_req(1, 0, 0, 0, 2, 0, "run_d1");
    do_req(1, 0, 0, 0, 2, 0, "run_d2");
    do_req(1, 0, 0, 0, 4, 0, "run_ok");
    do_req(1, 0, 0, 0, 2, 0, "run_d3");
    do_req(1, 0, 0, 0, 2, 0, "run_d4");
    do_req(1, 0, 0, 2, 4, 0, "run_ok2");

    // lockout: third consecutive denial, requests ignored while locked
    do_req(1, 0, 0, 0, 1, 0, "lk_d1");
    do_req(1, 0, 0, 0, 1, 0, "lk_d2");
    do_req(1, 0, 0, 0, 1, 0, "lk_d3");
    for (int i = 0; i < LOCK_CYC; i++) do_req(1, 1, 0, 0, 4, 8'h77, "lk_wait");
    do_req(1, 0, 0, 0, 4, 0, "lk_after");

    // lock the owner table
    do_req(1, 1, 1, 2, 4, 8'h83, "lock_wr");
    do_req(1, 1, 1, 2, 4, 8'h05, "locked_wr");
    do_req(1, 0, 1, 2, 6, 0, "locked_rd");
    do_req(1, 1, 0, 2, 3, 8'h5A, "new_owner_wr");
    idle(3, "locked_idle");

    // reset mid-lockout
    do_req(1, 0, 0, 3, 1, 0, "ml_d1");
    do_req(1, 0, 0, 3, 1, 0, "ml_d2");
    do_req(1, 0, 0, 3, 1, 0, "ml_d3");
    idle(5, "ml_idle");
    pulse_reset("mid_lockout");
    do_req(1, 0, 1, 2, 1, 0, "owner_after_rst");

    // reset mid-response
    do_req(1, 1, 0, 3, 4, 8'h99, "mr_wr");
    pulse_reset("mid_response");
    do_req(1, 0, 0, 3, 4, 0, "mr_rd");

    // viol_cnt saturation
    for (int k = 0; k < 90; k++) begin
      for (int j = 0; j < MAXV; j++) do_req(1, 0, 0, 1, 2, 0, "sat_deny");
      idle(LOCK_CYC, "sat_wait");
    end
    do_req(1, 0, 0, 1, 2, 0, "sat_more");
    pulse_reset("post_sat");

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      bit v, w, c;
      int a, id, wd;
      if (n == 300) pulse_reset("rand_mid");
      v  = ($urandom_range(0, 9) < 8);
      c  = ($urandom_range(0, 4) == 0);
      w  = $urandom_range(0, 1);
      a  = $urandom_range(0, NREG - 1);
      id = $urandom_range(1, 4);
      wd = $urandom_range(0, 255);
      if (c && w && $urandom_range(0, 7) != 0) wd = wd % 128;
      do_req(v, w, c, a, id, wd, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/access_ctrl_regfile.md
ACCESS_CTRL_REGFILE -- requirements
Module: access_ctrl_regfile

Interface
REQ-001 Parameter DATA_W, default 8: data width; SHALL be >= ID_W+2.
REQ-002 Parameter NUM_REGS, default 4: number of data registers and owner entries; SHALL be >= 2.
REQ-003 Parameter ID_W, default 3: user ID width.
REQ-004 Parameter ADMIN_ID, default 4: privileged user ID.
REQ-005 Parameter MAX_VIOL, default 3: consecutive denials that trigger lockout; SHALL be >= 1.
REQ-006 Parameter LOCKOUT_CYC, default 16: lockout duration in cycles; SHALL be >= 1.
REQ-007 clk  input  1  clock; all state changes on rising edge.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 req_valid  input  1  request present.
REQ-010 req_ready  output  1  block accepts a request this cycle.
REQ-011 req_write  input  1  1 = write, 0 = read.
REQ-012 req_cfg  input  1  1 = owner table, 0 = data registers.
REQ-013 req_addr  input  AW=max(1,$clog2(NUM_REGS))  register index.
REQ-014 req_id  input  ID_W  requesting user ID.
REQ-015 req_wdata  input  DATA_W  write data.
REQ-016 rsp_valid  output  1  one-cycle response strobe.
REQ-017 rsp_err  output  1  request denied or invalid; qualified by rsp_valid.
REQ-018 rsp_rdata  output  DATA_W  response data; qualified by rsp_valid.
REQ-019 cfg_locked  output  1  owner table locked.
REQ-020 lockout  output  1  block in LOCKOUT state.
REQ-021 viol_cnt  output  8  total denied requests since reset.

Function
REQ-022 Accept = req_valid && req_ready; rsp_valid SHALL be 1 exactly one cycle after each accept and 0 otherwise; no request is ever dropped silently.
REQ-023 Grant decision SHALL be computed from req_id/req_addr/req_cfg/req_write of the accept cycle itself; no grant value from any earlier cycle SHALL influence an access.
REQ-024 req_addr >= NUM_REGS: denied, no state change except violation counters.
REQ-025 Data read/write permitted iff req_id == owner[req_addr] or req_id == ADMIN_ID.
REQ-026 Permitted data write: data[req_addr] <= req_wdata at accept edge; rsp_rdata = req_wdata, rsp_err = 0.
REQ-027 Permitted data read: rsp_rdata = data[req_addr] as held in the accept cycle, rsp_err = 0.
REQ-028 Owner-table read: permitted for any ID; rsp_rdata = owner[req_addr] zero-extended.
REQ-029 Owner-table write: permitted iff req_id == ADMIN_ID and cfg_locked == 0; owner[req_addr] <= req_wdata[ID_W-1:0]; if req_wdata[DATA_W-1] == 1, cfg_locked <= 1 in the same edge; rsp_rdata = 0.
REQ-030 cfg_locked SHALL be sticky; only reset clears it.
REQ-031 Denied request: rsp_err = 1, rsp_rdata = 0, no data/owner/lock change.
REQ-032 viol_cnt increments by 1 per denial and saturates at 255.
REQ-033 Internal consecutive-denial counter: +1 per denial, cleared to 0 by any permitted access.
REQ-034 States: OPEN (req_ready = 1) and LOCKOUT (req_ready = 0, lockout = 1).
REQ-035 OPEN -> LOCKOUT on the edge of the accept whose denial makes the consecutive count reach MAX_VIOL; consecutive counter clears, timer loads LOCKOUT_CYC; the triggering response is still issued.
REQ-036 LOCKOUT: timer decrements each cycle; returns to OPEN on the edge where the timer is 1, so req_ready = 0 for exactly LOCKOUT_CYC cycles.

Reset
REQ-037 rst_n low at any time SHALL immediately force: data[*] = 0, owner[*] = ADMIN_ID, cfg_locked = 0, state OPEN, req_ready = 1, lockout = 0, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, viol_cnt = 0, consecutive counter = 0, timer = 0.
REQ-038 Any in-flight response or lockout is abandoned on reset; no response follows release.

Verification
REQ-039 Reset, then id=4 writes data[1]=0xA5 -> next cycle rsp_valid=1, rsp_err=0, rsp_rdata=0xA5; id=2 read of data[1] -> rsp_err=1, rsp_rdata=0, viol_cnt=1.
REQ-040 id=4 cfg write owner[1]=2 (wdata 0x02); id=2 writes data[1]=0x3C in the very next cycle -> accepted without error, data[1]=0x3C; id=3 read of data[1] -> rsp_err=1.
REQ-041 id=4 cfg write with wdata 0x83 -> owner=3, cfg_locked=1; further id=4 cfg write -> rsp_err=1, owner unchanged; cfg_locked remains 1 until rst_n asserted.
REQ-042 Back-to-back requests: id switches 4 -> 1 -> 4 each cycle on data[0] writes -> only id=4 writes land, errors exactly on the id=1 cycle.
REQ-043 Three consecutive denials (defaults) -> third gets rsp_err=1, req_ready=0 for exactly 16 cycles, then 1; a permitted access between denials resets the run and prevents lockout.
REQ-044 rst_n pulsed low mid-lockout and mid-response -> all outputs at reset values asynchronously, req_ready=1 after release.
